// File: rtl/game_ctrl_core.sv
// Game-control core: synchronised/debounced jump button, IDLE/RUN/DEAD run state,
// start-latched speed/difficulty levels and a phase-accumulator game tick.
module game_ctrl_core #(
  parameter int ACC_W           = 27,
  parameter int SPEED_IN_W      = 4,
  parameter int DIFF_IN_W       = 4,
  parameter int STEP_BASE       = 2,
  parameter int STEP_INC        = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                                 CLK100MHZ,
  input  logic                                 reset_btn,
  input  logic                                 jump_btn,
  input  logic [SPEED_IN_W-1:0]                speed_in,
  input  logic [DIFF_IN_W-1:0]                 difficulty_in,
  input  logic                                 isdead,
  output logic                                 jump_pulse,
  output logic                                 start_pulse,
  output logic                                 run,
  output logic                                 dead,
  output logic                                 game_tick,
  output logic [$clog2(SPEED_IN_W+1)-1:0]      speed_level,
  output logic [$clog2(DIFF_IN_W+1)-1:0]       difficulty_level
);

  localparam int SPD_LW = $clog2(SPEED_IN_W+1);
  localparam int DIF_LW = $clog2(DIFF_IN_W+1);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  // Level = 1 + index of highest set bit, 0 when the bus is empty.
  function automatic logic [SPD_LW-1:0] f_spd_lvl(input logic [SPEED_IN_W-1:0] v);
    f_spd_lvl = '0;
    for (int i = 0; i < SPEED_IN_W; i++)
      if (v[i]) f_spd_lvl = SPD_LW'(i + 1);
  endfunction

  function automatic logic [DIF_LW-1:0] f_dif_lvl(input logic [DIFF_IN_W-1:0] v);
    f_dif_lvl = '0;
    for (int i = 0; i < DIFF_IN_W; i++)
      if (v[i]) f_dif_lvl = DIF_LW'(i + 1);
  endfunction

  logic              r_sync1, r_sync2, r_stable, r_stable_d, r_jump_pulse;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_inc;

  state_t            r_state, w_next;
  logic              r_run, r_dead, r_start, r_tick;
  logic [SPD_LW-1:0] r_speed_level;
  logic [DIF_LW-1:0] r_diff_level;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W:0]    w_step_raw;
  logic [ACC_W-1:0]  w_step;
  logic [ACC_W:0]    w_sum;
  logic              w_start_go;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge CLK100MHZ) begin
    if (reset_btn) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_stable     <= 1'b0;
      r_stable_d   <= 1'b0;
      r_jump_pulse <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_sync1    <= jump_btn;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_jump_pulse <= r_stable & ~r_stable_d;
      if (r_sync2 != r_stable) begin
        if (w_cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_jump_pulse) w_next = S_RUN;
      S_RUN:   if (isdead)       w_next = S_DEAD;
      S_DEAD:  if (r_jump_pulse) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_start_go = (r_state == S_IDLE) && (w_next == S_RUN);

  // Step is formed one bit wider than the accumulator so saturation is visible.
  assign w_step_raw = (ACC_W+1)'(STEP_BASE) + (ACC_W+1)'(STEP_INC) * (ACC_W+1)'(r_speed_level);
  assign w_step     = (w_step_raw > {1'b0, {ACC_W{1'b1}}}) ? {ACC_W{1'b1}} : w_step_raw[ACC_W-1:0];
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_step};

  always_ff @(posedge CLK100MHZ) begin
    if (reset_btn) begin
      r_state       <= S_IDLE;
      r_run         <= 1'b0;
      r_dead        <= 1'b0;
      r_start       <= 1'b0;
      r_tick        <= 1'b0;
      r_acc         <= '0;
      r_speed_level <= '0;
      r_diff_level  <= '0;
    end else begin
      r_state <= w_next;
      r_run   <= (w_next == S_RUN);
      r_dead  <= (w_next == S_DEAD);
      r_start <= w_start_go;
      if (w_start_go) begin
        r_speed_level <= f_spd_lvl(speed_in);
        r_diff_level  <= f_dif_lvl(difficulty_in);
      end
      // Accumulate only while staying in RUN, so the tick never outlives run.
      if ((r_state == S_RUN) && (w_next == S_RUN)) begin
        r_acc  <= w_sum[ACC_W-1:0];
        r_tick <= w_sum[ACC_W];
      end else begin
        r_acc  <= '0;
        r_tick <= 1'b0;
      end
    end
  end

  assign jump_pulse       = r_jump_pulse;
  assign start_pulse      = r_start;
  assign run              = r_run;
  assign dead             = r_dead;
  assign game_tick        = r_tick;
  assign speed_level      = r_speed_level;
  assign difficulty_level = r_diff_level;

endmodule

// File: tb/tb_game_ctrl_core.sv
// Bench for game_ctrl_core: directed vector table and hand sequences plus random
// stimulus, all cross-checked each cycle against a behavioural game model.
module tb_game_ctrl_core;
  localparam int AW = 4;
  localparam int DC = 3;
  localparam int P_IDLE = 0, P_RUN = 1, P_DEAD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, jb, isdead;
  logic [3:0] spd, dif;
  logic       a_jp, a_start, a_run, a_dead, a_tick;
  logic       b_jp, b_start, b_run, b_dead, b_tick;
  logic [2:0] a_spd, a_dif, b_spd, b_dif;

  game_ctrl_core #(.ACC_W(AW), .SPEED_IN_W(4), .DIFF_IN_W(4), .STEP_BASE(2), .STEP_INC(1),
                   .DEBOUNCE_CYCLES(DC)) dut_a (
    .CLK100MHZ(clk), .reset_btn(rst), .jump_btn(jb), .speed_in(spd), .difficulty_in(dif),
    .isdead(isdead), .jump_pulse(a_jp), .start_pulse(a_start), .run(a_run), .dead(a_dead),
    .game_tick(a_tick), .speed_level(a_spd), .difficulty_level(a_dif));

  game_ctrl_core #(.ACC_W(AW), .SPEED_IN_W(4), .DIFF_IN_W(4), .STEP_BASE(15), .STEP_INC(4),
                   .DEBOUNCE_CYCLES(DC)) dut_b (
    .CLK100MHZ(clk), .reset_btn(rst), .jump_btn(jb), .speed_in(spd), .difficulty_in(dif),
    .isdead(isdead), .jump_pulse(b_jp), .start_pulse(b_start), .run(b_run), .dead(b_dead),
    .game_tick(b_tick), .speed_level(b_spd), .difficulty_level(b_dif));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: game phase, debounce run length and plain-integer accumulators.
  bit m_valid = 0;
  bit mq[$];
  bit m_stable, m_rose, m_jp, m_start;
  int m_run_len, m_phase, m_spd, m_dif;
  int m_acc[2];
  bit m_tick[2];
  int base[2] = '{2, 15};
  int inc[2]  = '{1, 4};

  function automatic int enc(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_edge();
    bit old_jp, seen;
    int old_phase, s;
    if (rst) begin
      mq = '{0, 0};
      m_stable = 0; m_rose = 0; m_jp = 0; m_start = 0; m_run_len = 0;
      m_phase = P_IDLE; m_spd = 0; m_dif = 0;
      m_acc = '{0, 0}; m_tick = '{0, 0};
      m_valid = 1;
      return;
    end
    if (!m_valid) return;
    old_jp = m_jp;
    old_phase = m_phase;
    seen = mq.pop_front();
    mq.push_back(jb);
    m_jp = m_rose;
    m_rose = 0;
    if (seen != m_stable) begin
      m_run_len++;
      if (m_run_len == DC) begin
        m_stable = seen; m_run_len = 0; m_rose = seen;
      end
    end else m_run_len = 0;
    m_start = 0;
    case (old_phase)
      P_IDLE: if (old_jp) begin
        m_phase = P_RUN; m_start = 1; m_spd = enc(spd); m_dif = enc(dif);
      end
      P_RUN:  if (isdead) m_phase = P_DEAD;
      default: if (old_jp) m_phase = P_IDLE;
    endcase
    for (int d = 0; d < 2; d++) begin
      if (old_phase == P_RUN && m_phase == P_RUN) begin
        s = base[d] + inc[d] * m_spd;
        if (s > (1 << AW) - 1) s = (1 << AW) - 1;
        m_acc[d] += s;
        m_tick[d] = (m_acc[d] >= (1 << AW));
        m_acc[d] = m_acc[d] % (1 << AW);
      end else begin
        m_acc[d] = 0; m_tick[d] = 0;
      end
    end
  endtask

  function automatic logic [10:0] mexp(input int d);
    return {m_jp, m_start, m_phase == P_RUN, m_phase == P_DEAD, m_tick[d], 3'(m_spd), 3'(m_dif)};
  endfunction

  int cyc = 0, t_run = 0, jp_cnt = 0, st_cnt = 0, b_ticks = 0;
  bit prev_run = 0;
  int ticks[$];

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (m_valid) begin
      chk("model_a", {a_jp, a_start, a_run, a_dead, a_tick, a_spd, a_dif}, mexp(0));
      chk("model_b", {b_jp, b_start, b_run, b_dead, b_tick, b_spd, b_dif}, mexp(1));
    end
    if (a_run && !prev_run) t_run = cyc;
    prev_run = a_run;
    if (a_tick) ticks.push_back(cyc - t_run);
    if (b_tick) b_ticks++;
    if (a_jp) jp_cnt++;
    if (a_start) st_cnt++;
  endtask

  task automatic press();
    jb = 1'b1;
    repeat (12) step();
    jb = 1'b0;
    repeat (8) step();
  endtask

  typedef struct {
    logic [3:0] spd;
    logic [3:0] dif;
    int lvl_s, lvl_d, first, second;
  } vec_t;
  vec_t tv[5];

  initial begin
    int lat, f, s2;
    tv[0] = '{4'b0000, 4'b1000, 0, 4, 8, 16};
    tv[1] = '{4'b0010, 4'b0000, 2, 0, 4, 8};
    tv[2] = '{4'b0110, 4'b0001, 3, 1, 4, 7};
    tv[3] = '{4'b1111, 4'b0101, 4, 3, 3, 6};
    tv[4] = '{4'b0001, 4'b1111, 1, 4, 6, 11};

    rst = 1'b1; jb = 1'b0; isdead = 1'b0; spd = '0; dif = '0;
    step(); step();
    chk("reset_state", {a_jp, a_start, a_run, a_dead, a_tick, a_spd, a_dif}, 0);
    rst = 1'b0;

    // Short glitch, then a clean press: one pulse, 6 cycles after the edge.
    jp_cnt = 0;
    jb = 1'b1; step(); step(); jb = 1'b0;
    repeat (10) step();
    chk("glitch_no_pulse", jp_cnt, 0);
    jb = 1'b1; lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (a_jp && lat < 0) lat = i;
    end
    chk("press_latency", lat, 6);
    jb = 1'b0;
    repeat (10) step();
    chk("press_one_pulse", jp_cnt, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("reset_after_press", {a_run, a_dead, a_tick, a_spd, a_dif}, 0);

    // Start/latch/tick-rate table.
    for (int v = 0; v < 5; v++) begin
      spd = tv[v].spd; dif = tv[v].dif;
      ticks.delete(); st_cnt = 0;
      press();
      repeat (4) step();
      chk("start_pulse_once", st_cnt, 1);
      chk("run_after_start", {a_run, a_dead}, 2'b10);
      chk("speed_level", a_spd, tv[v].lvl_s);
      chk("diff_level", a_dif, tv[v].lvl_d);
      f  = (ticks.size() > 0) ? ticks[0] : -1;
      s2 = (ticks.size() > 1) ? ticks[1] : -1;
      chk("first_tick", f, tv[v].first);
      chk("second_tick", s2, tv[v].second);
      spd = ~tv[v].spd; dif = ~tv[v].dif;
      step(); step();
      chk("levels_held", {a_spd, a_dif}, {3'(tv[v].lvl_s), 3'(tv[v].lvl_d)});
      isdead = 1'b1; step(); isdead = 1'b0;
      chk("dead_entry", {a_dead, a_run, a_tick}, 3'b100);
      ticks.delete();
      repeat (3) step();
      chk("no_tick_dead", ticks.size(), 0);
      press();
      chk("back_idle", {a_run, a_dead}, 2'b00);
      chk("levels_kept_idle", {a_spd, a_dif}, {3'(tv[v].lvl_s), 3'(tv[v].lvl_d)});
    end

    // isdead wins over a coincident jump pulse.
    spd = '0;
    press();
    jb = 1'b1;
    repeat (6) step();
    chk("prio_pulse_present", {a_jp, a_run}, 2'b11);
    isdead = 1'b1; step(); isdead = 1'b0;
    chk("prio_dead", {a_dead, a_run, a_tick}, 3'b100);
    repeat (6) step();
    jb = 1'b0;
    repeat (8) step();
    chk("prio_still_dead", {a_dead, a_run}, 2'b10);
    press();
    chk("prio_idle", {a_dead, a_run}, 2'b00);

    // Reset mid-run with acc at 6, then a restart ticks from zero.
    spd = '0; ticks.delete();
    jb = 1'b1;
    repeat (7) step();
    chk("rst_run_up", a_run, 1);
    jb = 1'b0;
    repeat (3) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_run", {a_jp, a_start, a_run, a_dead, a_tick, a_spd, a_dif}, 0);
    ticks.delete();
    repeat (10) step();
    chk("rst_stays_idle", {a_run, ticks.size() == 0}, 2'b01);
    press();
    repeat (4) step();
    f = (ticks.size() > 0) ? ticks[0] : -1;
    chk("rst_restart_tick", f, 8);
    isdead = 1'b1; step(); isdead = 1'b0;
    press();

    // Saturated step on dut_b: 15 ticks in any 16 running cycles.
    spd = 4'b1000; dif = 4'b0001;
    press();
    b_ticks = 0;
    repeat (16) step();
    chk("sat_ticks", b_ticks, 15);
    chk("sat_level", b_spd, 4);
    isdead = 1'b1; step(); isdead = 1'b0;
    press();

    // Random traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 300; k++) begin
      int hold;
      jb  = 1'($urandom);
      spd = 4'($urandom);
      dif = 4'($urandom);
      hold = $urandom_range(1, 12);
      for (int h = 0; h < hold; h++) begin
        isdead = ($urandom_range(0, 9) == 0);
        rst    = ($urandom_range(0, 199) == 0);
        step();
      end
    end
    rst = 1'b0; isdead = 1'b0; jb = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
